// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between the team's SPI master and a register-bank responder.
interface spi_reg_slave_if;
  logic SCLK;
  logic MOSI;
  logic ss;
  logic MISO;
  logic miso_oe;

  modport master (output SCLK, MOSI, ss, input MISO, miso_oe);
  modport slave  (input SCLK, MOSI, ss, output MISO, miso_oe);
endinterface

// File: rtl/spi_reg_slave.sv
// SPI register-bank responder: two-byte command/data frames, all SPI pins
// oversampled in the clk domain, read data returned on MISO in the same frame.
module spi_reg_slave #(
  parameter logic [1:0] mode      = 2'b00,
  parameter int          bits_size = 8,
  parameter int          num_regs  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  spi_reg_slave_if.slave                  spi,
  output logic [num_regs*bits_size-1:0]   regs_out,
  output logic                            wr_strobe,
  output logic [bits_size-2:0]            wr_addr,
  output logic [bits_size-1:0]            wr_data,
  output logic                            frame_err
);

  localparam int  CW   = $clog2(2*bits_size) + 1;
  localparam int  AW   = bits_size - 1;
  localparam bit  CPOL = mode[1];
  localparam bit  CPHA = mode[0];

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic [2:0]           sclk_q;
  logic [1:0]           mosi_q;
  logic [2:0]           ss_q;
  logic [bits_size-1:0] regs [num_regs];
  state_t               state;
  logic [CW-1:0]        bit_cnt;
  logic [bits_size-1:0] rx_sr;
  logic [bits_size-1:0] tx_sr;
  logic [bits_size-1:0] cmd_q;
  logic                 skip_shift;
  logic                 oe_q;

  logic                 sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                 sample_edge, shift_edge, ss_fall, ss_rise;
  logic [bits_size-1:0] rx_next;
  logic [bits_size-1:0] rd_data;
  logic                 wr_in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= '0;
      mosi_q <= '0;
      // NOTE: ss sync resets low so a pin that is already low after reset
      // shows no fall; a frame cut by reset is ignored until ss toggles.
      ss_q   <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi.SCLK};
      mosi_q <= {mosi_q[0], spi.MOSI};
      ss_q   <= {ss_q[1:0], spi.ss};
    end
  end

  always_comb begin
    sclk_rise   = sclk_q[1] & ~sclk_q[2];
    sclk_fall   = ~sclk_q[1] & sclk_q[2];
    lead_edge   = CPOL ? sclk_fall : sclk_rise;
    trail_edge  = CPOL ? sclk_rise : sclk_fall;
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    ss_fall     = ~ss_q[1] & ss_q[2];
    ss_rise     = ss_q[1] & ~ss_q[2];
    rx_next     = {rx_sr[bits_size-2:0], mosi_q[1]};
    wr_in_range = int'(cmd_q[AW-1:0]) < num_regs;
  end

  // Read mux indexed by the command byte as it completes; unmatched addresses read 0.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < num_regs; k++) begin
      if (rx_next[AW-1:0] == AW'(k)) rd_data = regs[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      cmd_q      <= '0;
      skip_shift <= 1'b0;
      oe_q       <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_err  <= 1'b0;
      // NOTE: the register bank is architectural state visible on regs_out,
      // so it is cleared by reset rather than left as an uninitialised RAM.
      for (int k = 0; k < num_regs; k++) regs[k] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      oe_q      <= ~ss_q[1];
      if (ss_rise) begin
        state <= IDLE;
        tx_sr <= '0;
        if (state == CMD || state == DATA) frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              state      <= CMD;
              bit_cnt    <= '0;
              rx_sr      <= '0;
              tx_sr      <= '0;
              skip_shift <= 1'b1;
            end
          end
          CMD, DATA: begin
            if (sample_edge) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (state == CMD && bit_cnt == CW'(bits_size-1)) begin
                state      <= DATA;
                cmd_q      <= rx_next;
                tx_sr      <= rx_next[bits_size-1] ? rd_data : '0;
                skip_shift <= 1'b1;
              end else if (state == DATA && bit_cnt == CW'(2*bits_size-1)) begin
                state <= DONE;
                tx_sr <= '0;
                if (!cmd_q[bits_size-1] && wr_in_range) begin
                  for (int k = 0; k < num_regs; k++) begin
                    if (cmd_q[AW-1:0] == AW'(k)) regs[k] <= rx_next;
                  end
                  wr_strobe <= 1'b1;
                  wr_addr   <= cmd_q[AW-1:0];
                  wr_data   <= rx_next;
                end
              end
            end else if (shift_edge) begin
              // Holding the first shift after a load keeps the new MSB valid
              // through the next sample edge in every mode.
              if (skip_shift) skip_shift <= 1'b0;
              else            tx_sr      <= {tx_sr[bits_size-2:0], 1'b0};
            end
          end
          DONE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < num_regs; g++) begin : g_flat
    assign regs_out[g*bits_size +: bits_size] = regs[g];
  end

  assign spi.MISO    = tx_sr[bits_size-1] & oe_q;
  assign spi.miso_oe = oe_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: one instance per SPI mode, a bit-banged master,
// a frame-level register model and a scoreboard monitor for strobe/error pulses.
module tb_spi_reg_slave;
  localparam int BS = 8;
  localparam int NR = 8;
  localparam int H  = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             sclk [4];
  logic             mosi [4];
  logic             ss   [4];
  logic             miso [4];
  logic             miso_oe [4];
  logic [NR*BS-1:0] regs_out [4];
  logic             wr_strobe [4];
  logic [BS-2:0]    wr_addr [4];
  logic [BS-1:0]    wr_data [4];
  logic             frame_err [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_reg_slave_if sif ();
    assign sif.SCLK    = sclk[g];
    assign sif.MOSI    = mosi[g];
    assign sif.ss      = ss[g];
    assign miso[g]     = sif.MISO;
    assign miso_oe[g]  = sif.miso_oe;

    spi_reg_slave #(.mode(2'(g)), .bits_size(BS), .num_regs(NR)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .spi       (sif),
      .regs_out  (regs_out[g]),
      .wr_strobe (wr_strobe[g]),
      .wr_addr   (wr_addr[g]),
      .wr_data   (wr_data[g]),
      .frame_err (frame_err[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  model [4][NR];
  logic [14:0] exp_wr_q [4][$];
  int          exp_err_q [4][$];

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (mode %0d): got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  function automatic logic [63:0] model_flat(input int k);
    logic [63:0] f = '0;
    for (int a = 0; a < NR; a++) f[a*8 +: 8] = model[k][a];
    return f;
  endfunction

  // Scoreboard monitor: every strobe/error pulse must match a queued expectation.
  logic [14:0] mon_e;
  int          mon_idx;
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_strobe[k] === 1'b1) begin
        if (exp_wr_q[k].size() == 0) check("unexpected_wr_strobe", k, 64'd1, 64'd0);
        else begin
          mon_e   = exp_wr_q[k].pop_front();
          mon_idx = int'(mon_e[14:8]);
          check("wr_addr", k, 64'(wr_addr[k]), 64'(mon_e[14:8]));
          check("wr_data", k, 64'(wr_data[k]), 64'(mon_e[7:0]));
          check("wr_reg_value", k, 64'(regs_out[k][mon_idx*8 +: 8]), 64'(mon_e[7:0]));
        end
      end
      if (frame_err[k] === 1'b1) begin
        if (exp_err_q[k].size() == 0) check("unexpected_frame_err", k, 64'd1, 64'd0);
        else begin
          void'(exp_err_q[k].pop_front());
          check("frame_err_pulse", k, 64'd1, 64'd1 & 64'(frame_err[k]));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("reset_regs_out", k, regs_out[k], 64'd0);
      check("reset_outputs", k,
            64'({wr_strobe[k], frame_err[k], miso[k], miso_oe[k], wr_addr[k], wr_data[k]}), 64'd0);
      for (int a = 0; a < NR; a++) model[k][a] = 8'h00;
    end
  endtask

  // One ss window of nbits SCLK cycles; rst_at > 0 pulses reset after that many bits.
  task automatic spi_frame(input int k, input logic [23:0] bits, input int nbits, input int rst_at);
    logic        cpol, cpha;
    logic [23:0] got, exp, mask;
    logic [7:0]  cmd;
    int          a;
    cpol = k[1];
    cpha = k[0];
    got  = '0;
    exp  = '0;
    cmd  = bits[23:16];
    a    = int'(cmd[6:0]);
    if (rst_at == 0) begin
      if (nbits < 16) exp_err_q[k].push_back(1);
      else if (cmd[7]) exp[15:8] = (a < NR) ? model[k][a] : 8'h00;
      else if (a < NR) begin
        model[k][a] = bits[15:8];
        exp_wr_q[k].push_back({cmd[6:0], bits[15:8]});
      end
    end
    @(negedge clk);
    ss[k] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi[k] = bits[23-i];
        repeat (H) @(negedge clk);
        sclk[k] = ~cpol;
        got[23-i] = miso[k];
        repeat (H) @(negedge clk);
        sclk[k] = cpol;
      end else begin
        sclk[k] = ~cpol;
        mosi[k] = bits[23-i];
        repeat (H) @(negedge clk);
        sclk[k] = cpol;
        got[23-i] = miso[k];
        repeat (H) @(negedge clk);
      end
      if (i + 1 == rst_at) do_reset();
    end
    repeat (H) @(negedge clk);
    ss[k] = 1'b1;
    repeat (8) @(negedge clk);
    mask = ~(24'hFFFFFF >> nbits);
    check("miso_bits", k, 64'(got & mask), 64'(exp & mask));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      sclk[k] = k[1];
      mosi[k] = 1'b0;
      ss[k]   = 1'b1;
      for (int a = 0; a < NR; a++) model[k][a] = 8'h00;
    end
    repeat (4) @(negedge clk);
    do_reset();
    repeat (4) @(negedge clk);

    spi_frame(0, 24'h03A500, 16, 0);
    check("reg3_after_write", 0, 64'(regs_out[0][31:24]), 64'hA5);

    for (int k = 0; k < 4; k++) begin
      spi_frame(k, 24'h053C00, 16, 0);
      spi_frame(k, 24'h850000, 16, 0);
    end

    spi_frame(0, 24'hFF0000, 16, 0);
    spi_frame(0, 24'h7F1100, 16, 0);
    check("regs_after_oor_write", 0, regs_out[0], model_flat(0));

    spi_frame(0, 24'h02EE00, 11, 0);
    check("reg2_after_abort", 0, 64'(regs_out[0][23:16]), 64'(model[0][2]));
    spi_frame(0, 24'h025A00, 16, 0);
    spi_frame(0, 24'h820000, 16, 0);

    spi_frame(2, 24'h017799, 24, 0);
    check("reg1_after_long_frame", 2, 64'(regs_out[2][15:8]), 64'h77);

    spi_frame(1, 24'h046600, 16, 12);
    spi_frame(1, 24'h042100, 16, 0);
    spi_frame(1, 24'h840000, 16, 0);

    for (int r = 0; r < 40; r++) begin
      int          k, a;
      logic        rd;
      logic [7:0]  d;
      k  = int'($urandom_range(0, 3));
      rd = 1'($urandom_range(0, 1));
      a  = int'($urandom_range(0, 9));
      d  = 8'($urandom);
      spi_frame(k, {rd, 7'(a), d, 8'h00}, 16, 0);
    end

    repeat (20) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("final_regs", k, regs_out[k], model_flat(k));
      check("pending_wr_strobes", k, 64'(exp_wr_q[k].size()), 64'd0);
      check("pending_frame_errs", k, 64'(exp_err_q[k].size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
